// File: rtl/iterator_loop_sequencer.sv
// iterator_loop_sequencer
//   Single-level loop sequencer placed in front of the iterator address
//   generator. The first pass of a loop body is forwarded straight through
//   while being captured. The remaining iterations are replayed from the
//   internal buffer. in_loop tells the address generator to write back
//   base+stride. After the last body instruction, a short drain window lets
//   those write-backs settle before new work is accepted.
//
//   Ports
//     clk, reset                  clock, synchronous active-high reset
//     cfg_valid/num_iter/num_inst loop configuration (accepted only in IDLE)
//     cfg_err                     1-cycle pulse when a config is rejected
//     inst_in_*                   upstream instruction stream (valid/ready)
//     inst_out_*                  downstream instruction stream (valid/ready)
//     in_loop                     high while body instructions are issued
//     busy                        high outside IDLE
//     iter_count                  iterations completed in the current loop
//     loop_done                   1-cycle pulse when loop and drain complete
//
//   state  | meaning
//   IDLE   | pass-through; waiting for a loop config
//   FILL   | pass-through of the first body pass while capturing it
//   REPLAY | issuing the stored body; upstream held off
//   DRAIN  | quiet window for in-flight iterator write-backs
module iterator_loop_sequencer #(
    parameter int INST_WIDTH   = 32,
    parameter int BODY_DEPTH   = 16,
    parameter int ITER_BITS    = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    input  logic [ITER_BITS-1:0]          cfg_num_iter,
    input  logic [$clog2(BODY_DEPTH):0]   cfg_num_inst,
    output logic                          cfg_err,
    input  logic                          inst_in_valid,
    output logic                          inst_in_ready,
    input  logic [INST_WIDTH-1:0]         inst_in,
    output logic                          inst_out_valid,
    input  logic                          inst_out_ready,
    output logic [INST_WIDTH-1:0]         inst_out,
    output logic                          in_loop,
    output logic                          busy,
    output logic [ITER_BITS-1:0]          iter_count,
    output logic                          loop_done
);

    localparam int PTR_W   = $clog2(BODY_DEPTH);
    localparam int NUM_W   = PTR_W + 1;
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_REPLAY,
        ST_DRAIN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ITER_BITS-1:0]   num_iter_q;
    logic [NUM_W-1:0]       num_inst_q;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ITER_BITS-1:0]   iter_count_q;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   cfg_err_q;
    logic                   loop_done_q;
    logic [INST_WIDTH-1:0]  body_mem [BODY_DEPTH];

    logic cfg_ok;
    logic cfg_bad;
    logic fill_wr;
    logic fill_last;
    logic rep_adv;
    logic rep_wrap;
    logic iter_last;
    logic drain_tc;
    logic body_end_wr;
    logic body_end_rd;

    // Pointers are compared against num_inst-1 with one extra bit so a full
    // BODY_DEPTH body is handled without aliasing.
    assign body_end_wr = ({1'b0, wr_ptr} == (num_inst_q - NUM_W'(1)));
    assign body_end_rd = ({1'b0, rd_ptr} == (num_inst_q - NUM_W'(1)));
    assign iter_last   = ((iter_count_q + ITER_BITS'(1)) == num_iter_q);

    always_comb begin
        state_nxt      = state;
        inst_out       = inst_in;
        inst_out_valid = inst_in_valid;
        inst_in_ready  = inst_out_ready;
        in_loop        = 1'b0;
        cfg_ok         = 1'b0;
        cfg_bad        = 1'b0;
        fill_wr        = 1'b0;
        fill_last      = 1'b0;
        rep_adv        = 1'b0;
        rep_wrap       = 1'b0;
        drain_tc       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if ((cfg_num_inst != '0) && (cfg_num_inst <= NUM_W'(BODY_DEPTH))) begin
                        cfg_ok    = 1'b1;
                        state_nxt = ST_FILL;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                in_loop = 1'b1;
                if (inst_in_valid && inst_out_ready) begin
                    fill_wr = 1'b1;
                    if (body_end_wr) begin
                        fill_last = 1'b1;
                        state_nxt = (num_iter_q == ITER_BITS'(1)) ? ST_DRAIN : ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                inst_in_ready  = 1'b0;
                inst_out       = body_mem[rd_ptr];
                inst_out_valid = 1'b1;
                in_loop        = 1'b1;
                if (inst_out_ready) begin
                    rep_adv = 1'b1;
                    if (body_end_rd) begin
                        rep_wrap = 1'b1;
                        if (iter_last) begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                inst_in_ready  = 1'b0;
                inst_out_valid = 1'b0;
                if (drain_cnt == '0) begin
                    drain_tc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            num_iter_q   <= '0;
            num_inst_q   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            iter_count_q <= '0;
            drain_cnt    <= '0;
            cfg_err_q    <= 1'b0;
            loop_done_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_err_q   <= cfg_bad;
            loop_done_q <= drain_tc;

            // Down-counter preloaded outside DRAIN; terminal count ends the window.
            if (state != ST_DRAIN) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else if (!drain_tc) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end

            if (cfg_ok) begin
                num_iter_q   <= (cfg_num_iter == '0) ? ITER_BITS'(1) : cfg_num_iter;
                num_inst_q   <= cfg_num_inst;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                iter_count_q <= '0;
            end

            if (fill_wr) begin
                if (fill_last) begin
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    iter_count_q <= ITER_BITS'(1);
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end

            if (rep_adv) begin
                if (rep_wrap) begin
                    rd_ptr       <= '0;
                    iter_count_q <= iter_count_q + ITER_BITS'(1);
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Body storage carries no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            body_mem[wr_ptr] <= inst_in;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign loop_done  = loop_done_q;
    assign iter_count = iter_count_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_iterator_loop_sequencer.sv
module tb_iterator_loop_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [15:0] cfg_num_iter;
    logic [4:0]  cfg_num_inst;
    logic        cfg_err;
    logic        inst_in_valid;
    logic        inst_in_ready;
    logic [31:0] inst_in;
    logic        inst_out_valid;
    logic        inst_out_ready;
    logic [31:0] inst_out;
    logic        in_loop;
    logic        busy;
    logic [15:0] iter_count;
    logic        loop_done;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] body [16];
    logic [3:0]  stall_pat = 4'b1001;

    always #5 clk = ~clk;

    iterator_loop_sequencer #(
        .INST_WIDTH(32), .BODY_DEPTH(16), .ITER_BITS(16), .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_num_iter(cfg_num_iter), .cfg_num_inst(cfg_num_inst),
        .cfg_err(cfg_err),
        .inst_in_valid(inst_in_valid), .inst_in_ready(inst_in_ready), .inst_in(inst_in),
        .inst_out_valid(inst_out_valid), .inst_out_ready(inst_out_ready), .inst_out(inst_out),
        .in_loop(in_loop), .busy(busy), .iter_count(iter_count), .loop_done(loop_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Configure a loop and push the first body pass through FILL.
    task automatic start_loop(input int iters, input int n);
        @(negedge clk);
        cfg_valid      = 1'b1;
        cfg_num_iter   = 16'(iters);
        cfg_num_inst   = 5'(n);
        inst_in_valid  = 1'b0;
        inst_out_ready = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1 chk("cfg_busy", 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            inst_in_valid  = 1'b1;
            inst_in        = body[i];
            inst_out_ready = 1'b1;
            #1;
            chk("fill_out", 64'(inst_out), 64'(body[i]));
            chk("fill_loop", 64'(in_loop), 64'd1);
            chk("fill_rdy", 64'(inst_in_ready), 64'd1);
            @(negedge clk);
        end
        inst_in_valid = 1'b0;
    endtask

    // Replay the remaining iterations (optionally stalling downstream) and check drain.
    task automatic finish_loop(input int iters, input int n, input bit stall);
        int exp_it;
        int total;
        int idx;
        int cyc;
        exp_it = (iters == 0) ? 1 : iters;
        total  = (exp_it - 1) * n;
        idx    = 0;
        cyc    = 0;
        while (idx < total && cyc < 200) begin
            inst_in_valid  = 1'b1;
            inst_in        = 32'hDEAD_0000 + 32'(cyc);
            inst_out_ready = stall ? stall_pat[cyc % 4] : 1'b1;
            #1;
            chk("rep_out", 64'(inst_out), 64'(body[idx % n]));
            chk("rep_valid", 64'(inst_out_valid), 64'd1);
            chk("rep_rdy", 64'(inst_in_ready), 64'd0);
            chk("rep_loop", 64'(in_loop), 64'd1);
            chk("rep_iter", 64'(iter_count), 64'(1 + idx / n));
            if (inst_out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        if (idx < total) chk("rep_timeout", 64'(idx), 64'(total));
        inst_in_valid  = 1'b0;
        inst_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drn_done", 64'(loop_done), 64'd0);
            chk("drn_busy", 64'(busy), 64'd1);
            chk("drn_loop", 64'(in_loop), 64'd0);
            chk("drn_oval", 64'(inst_out_valid), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("done", 64'(loop_done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_iter", 64'(iter_count), 64'(exp_it));
        @(negedge clk);
        #1;
        chk("done_pulse", 64'(loop_done), 64'd0);
        chk("iter_hold", 64'(iter_count), 64'(exp_it));
    endtask

    task automatic bad_cfg(input int n);
        @(negedge clk);
        cfg_valid    = 1'b1;
        cfg_num_iter = 16'd2;
        cfg_num_inst = 5'(n);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("cfg_err", 64'(cfg_err), 64'd1);
        chk("cfg_err_idle", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        chk("cfg_err_pulse", 64'(cfg_err), 64'd0);
        chk("cfg_err_idle2", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_num_iter   = '0;
        cfg_num_inst   = '0;
        inst_in_valid  = 1'b0;
        inst_in        = '0;
        inst_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_loop", 64'(in_loop), 64'd0);
        chk("rst_iter", 64'(iter_count), 64'd0);
        chk("rst_done", 64'(loop_done), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);

        // Idle pass-through
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_in_valid  = 1'b1;
            inst_in        = 32'h1000_0000 + 32'(i * 7);
            inst_out_ready = 1'b1;
            #1;
            chk("idle_out", 64'(inst_out), 64'(32'h1000_0000 + 32'(i * 7)));
            chk("idle_oval", 64'(inst_out_valid), 64'd1);
            chk("idle_rdy", 64'(inst_in_ready), 64'd1);
            chk("idle_loop", 64'(in_loop), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end
        inst_out_ready = 1'b0;
        #1 chk("idle_rdy_low", 64'(inst_in_ready), 64'd0);
        inst_in_valid  = 1'b0;
        inst_out_ready = 1'b1;

        // 3 iterations of A,B
        body[0] = 32'hAAAA_0001;
        body[1] = 32'hBBBB_0002;
        start_loop(3, 2);
        finish_loop(3, 2, 1'b0);

        // iteration count 0 behaves as 1
        body[0] = 32'h5858_5858;
        start_loop(0, 1);
        finish_loop(0, 1, 1'b0);

        // rejected configs
        bad_cfg(0);
        bad_cfg(17);

        // stalled replay
        body[0] = 32'hC0C0_0003;
        body[1] = 32'hD0D0_0004;
        body[2] = 32'hE0E0_0005;
        start_loop(2, 3);
        finish_loop(2, 3, 1'b1);

        // full-depth body, two iterations
        for (int i = 0; i < 16; i++) body[i] = 32'hF000_0000 + 32'(i);
        start_loop(2, 16);
        finish_loop(2, 16, 1'b0);

        // reset in the middle of iteration 2 of 5
        body[0] = 32'h7070_0006;
        body[1] = 32'h8080_0007;
        start_loop(5, 2);
        inst_out_ready = 1'b1;
        #1 chk("mid_out", 64'(inst_out), 64'(body[0]));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_loop", 64'(in_loop), 64'd0);
        chk("mid_rst_iter", 64'(iter_count), 64'd0);
        chk("mid_rst_done", 64'(loop_done), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1 chk("mid_no_done", 64'(loop_done), 64'd0);
        end
        body[0] = 32'h9191_0008;
        body[1] = 32'h9292_0009;
        start_loop(2, 2);
        finish_loop(2, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
